// File: rtl/demux1t2_5_buf_pkg.sv
// Shared definitions for the 1-to-2 registered 5-bit demultiplexer.
package demux_pkg;

    localparam int WIDTH_DEF = 5;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_st_t;

endpackage

// File: rtl/demux1t2_5_buf_out_slot.sv
// One-entry output register slice with valid/ready drain and a delivered-word counter.
module out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt,
    output logic             can_accept
);

    slot_st_t         r_state;
    slot_st_t         w_next_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_drain;

    assign w_drain    = (r_state == FULL) && rd_ready;
    assign valid      = (r_state == FULL);
    assign data       = r_data;
    assign cnt        = r_cnt;
    // A full slot can still take a word in the same cycle it is drained.
    assign can_accept = (r_state == EMPTY) || rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            EMPTY: if (wr) w_next_state = FULL;
            FULL:  if (w_drain && !wr) w_next_state = EMPTY;
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (wr) begin
            r_data <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux1t2_5_buf.sv
// Registered 1-to-2 demultiplexer: routes each accepted word to one of two buffered outputs.
module demux1t2_5_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic w_can0;
    logic w_can1;
    logic w_acc;
    logic w_wr0;
    logic w_wr1;

    // Ready depends only on the selected slot, so a stalled consumer never blocks the other.
    assign in_ready = s ? w_can1 : w_can0;
    assign w_acc    = in_valid && in_ready;
    assign w_wr0    = w_acc && !s;
    assign w_wr1    = w_acc && s;

    out_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (w_wr0),
        .wdata     (in_data),
        .rd_ready  (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data),
        .cnt       (cnt0),
        .can_accept(w_can0)
    );

    out_slot #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (w_wr1),
        .wdata     (in_data),
        .rd_ready  (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .cnt       (cnt1),
        .can_accept(w_can1)
    );

endmodule
